// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and rotating-priority pick for rr_arbiter8.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // First set bit of mask when scanning from ptr+1 upward, modulo N_REQ.
  // The scan runs from farthest to nearest so the nearest hit is written last.
  // Offset N_REQ wraps back to ptr itself, which therefore has lowest priority.
  // The caller only uses the result when mask is non-zero.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    rr_pick = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ptr + IDX_W'(k);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module dec3to8 (
  input  logic [2:0] idx_i,
  input  logic       en_i,
  output logic [7:0] onehot_o
);

  // Drive exactly one bit high when enabled.
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered owner, rotating priority and
// a hold limit that revokes a long-running owner while others are waiting.
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             pre_q, pre_d;

  logic [N_REQ-1:0] others;
  logic             contended;
  logic             expired;

  // Everyone except the current owner; drives both release and hold-limit decisions.
  assign others    = req & ~(N_REQ'(1) << idx_q);
  assign contended = |others;
  assign expired   = contended && (hold_q == CNT_W'(MAX_HOLD - 1));

  // Next-state logic: owner selection, hold counting and preempt pulse.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    pre_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = rr_pick(req, ptr_q);
          ptr_d   = rr_pick(req, ptr_q);
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          // Owner released; hand over with no dead cycle if anyone is waiting.
          if (contended) begin
            idx_d  = rr_pick(others, ptr_q);
            ptr_d  = rr_pick(others, ptr_q);
            hold_d = '0;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else if (expired) begin
          idx_d  = rr_pick(others, ptr_q);
          ptr_d  = rr_pick(others, ptr_q);
          hold_d = '0;
          pre_d  = 1'b1;
        end else if (contended) begin
          hold_d = hold_q + CNT_W'(1);
        end else begin
          // A lone requester never ages toward the limit.
          hold_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; ptr resets to the last index so bit 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      hold_q  <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      pre_q   <= pre_d;
    end
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = idx_q;
  assign preempt   = pre_q;

  dec3to8 u_dec (
    .idx_i    (idx_q),
    .en_i     (gnt_valid),
    .onehot_o (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_rr_arbiter8;

  localparam int MAXH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  rr_arbiter8 #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_own  = 0;
  int         m_ptr  = 7;
  int         m_hold = 0;
  logic       m_vld  = 1'b0;
  logic       m_pre  = 1'b0;
  logic [7:0] m_oth;

  function automatic int mpick(input logic [7:0] m, input int p);
    for (int off = 1; off <= 8; off++)
      if (m[(p + off) % 8]) return (p + off) % 8;
    return -1;
  endfunction

  assign m_oth = req & ~(8'(1) << m_own);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 1'b0; m_own <= 0; m_ptr <= 7; m_hold <= 0; m_pre <= 1'b0;
    end else begin
      m_pre <= 1'b0;
      if (!m_vld) begin
        if (req != 8'h00) begin
          m_own <= mpick(req, m_ptr); m_ptr <= mpick(req, m_ptr);
          m_hold <= 0; m_vld <= 1'b1;
        end
      end else if (!req[m_own]) begin
        if (m_oth != 8'h00) begin
          m_own <= mpick(m_oth, m_ptr); m_ptr <= mpick(m_oth, m_ptr); m_hold <= 0;
        end else begin
          m_vld <= 1'b0; m_hold <= 0;
        end
      end else if (m_oth != 8'h00 && m_hold == MAXH - 1) begin
        m_own <= mpick(m_oth, m_ptr); m_ptr <= mpick(m_oth, m_ptr);
        m_hold <= 0; m_pre <= 1'b1;
      end else if (m_oth != 8'h00) begin
        m_hold <= m_hold + 1;
      end else begin
        m_hold <= 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_gnt", 32'(gnt), m_vld ? 32'(8'(1) << m_own) : 32'd0);
      chk("m_valid", 32'(gnt_valid), 32'(m_vld));
      chk("m_preempt", 32'(preempt), 32'(m_pre));
      if (m_vld) chk("m_idx", 32'(gnt_idx), 32'(m_own));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    req   = 8'h00;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] oh;
    int o;
    int r;

    // Reset values
    #1;
    chk("rst_gnt", 32'(gnt), 32'h00);
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    chk("rst_idx", 32'(gnt_idx), 32'd0);
    chk("rst_preempt", 32'(preempt), 32'd0);
    #2 rst_n = 1'b1;

    // Single request, one-cycle latency
    req = 8'h01;
    step();
    chk("first_gnt", 32'(gnt), 32'h01);
    chk("first_idx", 32'(gnt_idx), 32'd0);
    chk("first_valid", 32'(gnt_valid), 32'd1);

    // All requesting, each owner drops after 3 cycles
    do_reset();
    req = 8'hFF;
    step();
    for (int k = 0; k <= 8; k++) begin
      o  = k % 8;
      oh = 8'(1) << o;
      for (int c = 0; c < 3; c++) begin
        chk("rot_gnt", 32'(gnt), 32'(oh));
        if (c < 2) step();
      end
      req[o] = 1'b0;
      step();
      req[o] = 1'b1;
    end

    // Hold limit with req=05
    do_reset();
    req = 8'h05;
    step();
    chk("hold_first", 32'(gnt), 32'h01);
    for (int c = 0; c < 15; c++) begin
      step();
      chk("hold_own0", 32'(gnt), 32'h01);
      chk("hold_nopre0", 32'(preempt), 32'd0);
    end
    step();
    chk("pre_gnt2", 32'(gnt), 32'h04);
    chk("pre_pulse2", 32'(preempt), 32'd1);
    for (int c = 0; c < 15; c++) begin
      step();
      chk("hold_own2", 32'(gnt), 32'h04);
      chk("hold_nopre2", 32'(preempt), 32'd0);
    end
    step();
    chk("pre_gnt0", 32'(gnt), 32'h01);
    chk("pre_pulse0", 32'(preempt), 32'd1);

    // Lone requester never preempted
    do_reset();
    req = 8'h08;
    step();
    for (int c = 0; c < 100; c++) begin
      chk("lone_gnt", 32'(gnt), 32'h08);
      chk("lone_pre", 32'(preempt), 32'd0);
      step();
    end

    // Asynchronous reset mid-grant; pointer returns to 7
    do_reset();
    req = 8'h20;
    step();
    chk("pre_rst_gnt", 32'(gnt), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'h00);
    chk("async_rst_valid", 32'(gnt_valid), 32'd0);
    rst_n = 1'b1;
    req   = 8'h22;
    step();
    chk("post_rst_gnt", 32'(gnt), 32'h02);

    // Owner 6 drops as 7 and 2 rise
    do_reset();
    req = 8'h40;
    step();
    chk("own6", 32'(gnt), 32'h40);
    req = 8'h84;
    step();
    chk("next7", 32'(gnt), 32'h80);
    chk("next7_idx", 32'(gnt_idx), 32'd7);

    // Randomized traffic; model comparison runs every cycle
    do_reset();
    req = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      step();
      r = int'($urandom_range(0, 199));
      if (r < 24) req[$urandom_range(0, 7)] = ~req[$urandom_range(0, 7)];
      else if (r < 28) req = 8'($urandom);
      else if (r < 30) req = 8'h00;
      else if (r == 30) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
